// File: rtl/serial_adder_unit.sv
// Bit-serial add/subtract unit: one full-adder cell plus a registered carry,
// one operand bit per clock LSB first, with a start/busy/done handshake.

module adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, result;
  logic [CW-1:0]    count;
  logic             carry, cmsb;
  logic             bit_s, bit_c;
  logic [WIDTH-1:0] next_result;

  adder_bit u_adder_bit (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign next_result = {bit_s, result[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next-state gets its default first, so no path through the case
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sa       <= '0;
      sb       <= '0;
      result   <= '0;
      count    <= '0;
      carry    <= 1'b0;
      cmsb     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            sa    <= a;
            sb    <= b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
          end
        end
        RUN: begin
          result <= next_result;
          carry  <= bit_c;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          // Carry into the MSB, needed for the signed-overflow flag.
          if (count == PENULT) cmsb <= bit_c;
          if (count == LAST) begin
            sum      <= next_result;
            cout     <= bit_c;
            overflow <= cmsb ^ bit_c;
            zero     <= (next_result == '0);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench for serial_adder_unit: arithmetic reference model with a
// per-cycle compare process, directed corner cases and randomized operations.

module tb_serial_adder_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] sum;

  serial_adder_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  // Result from plain arithmetic: exact signed value decides overflow,
  // unsigned comparison decides the borrow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t     r;
    logic [W:0] wide;
    longint   ex, lim;
    lim = longint'(1) << (W - 1);
    if (!s) begin
      wide   = {1'b0, x} + {1'b0, y};
      r.sum  = x + y;
      r.cout = wide[W];
      ex     = longint'($signed(x)) + longint'($signed(y));
    end else begin
      r.sum  = x - y;
      r.cout = (x >= y);
      ex     = longint'($signed(x)) - longint'($signed(y));
    end
    r.ovf  = (ex >= lim) || (ex < -lim);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Transaction-level model: an accepted request occupies the unit for
  // W+1 edges after acceptance; results appear W edges after acceptance.
  logic m_active = 1'b0;
  int   m_cnt    = 0;
  res_t m_pend   = '0;
  res_t m_out    = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_out    <= '0;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == W)     m_out    <= m_pend;
      if (m_cnt + 1 == W + 1) m_active <= 1'b0;
    end else if (start) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
      m_pend   <= model(a, b, sub);
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     {63'd0, busy},     {63'd0, m_active});
      check("done",     {63'd0, done},     {63'd0, m_active && (m_cnt == W)});
      check("sum",      {32'd0, sum},      {32'd0, m_out.sum});
      check("cout",     {63'd0, cout},     {63'd0, m_out.cout});
      check("overflow", {63'd0, overflow}, {63'd0, m_out.ovf});
      check("zero",     {63'd0, zero},     {63'd0, m_out.zero});
    end
  end

  // Issue one request, scramble the inputs after acceptance, and wait for done.
  // lat counts edges from the accepting edge through the one that raises done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        output int lat, output logic busy_next);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
    busy_next = busy;
    lat = 1;
    while (!done && lat < W + 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
    check({tag, "_sum"},  {32'd0, sum},      {32'd0, es});
    check({tag, "_cout"}, {63'd0, cout},     {63'd0, ec});
    check({tag, "_ovf"},  {63'd0, overflow}, {63'd0, eo});
    check({tag, "_zero"}, {63'd0, zero},     {63'd0, ez});
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  int   lat, nd;
  logic bn;

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    expect_res("reset", '0, 1'b0, 1'b0, 1'b0);
    check("reset_busy", {63'd0, busy}, 64'd0);

    // Basic add with timing.
    run_op(32'd5, 32'd7, 1'b0, lat, bn);
    check("busy_rise", {63'd0, bn}, 64'd1);
    check("latency_add", 64'(lat), 64'(W + 1));
    expect_res("add5_7", 32'd12, 1'b0, 1'b0, 1'b0);
    check("model_pin_sum", {32'd0, m_out.sum}, 64'd12);

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bn);
    expect_res("wrap", 32'd0, 1'b1, 1'b0, 1'b1);
    check("model_pin_zero", {63'd0, m_out.zero}, 64'd1);

    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, lat, bn);
    expect_res("pos_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    run_op(32'd5, 32'd7, 1'b1, lat, bn);
    check("latency_sub", 64'(lat), 64'(W + 1));
    expect_res("sub5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    run_op(32'h8000_0000, 32'd1, 1'b1, lat, bn);
    expect_res("neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    check("model_pin_ovf", {63'd0, m_out.ovf}, 64'd1);

    // Starts during RUN and on the done cycle are ignored.
    @(negedge clk);
    a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < W + 10) begin
      @(negedge clk);
      lat++;
      start = (lat == 10);
      a = (lat == 10) ? 32'd99 : 32'd1;
    end
    check("ignore_latency", 64'(lat), 64'(W + 1));
    expect_res("ignore", 32'd2, 1'b0, 1'b0, 1'b0);
    a = 32'd50; b = 32'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore_idle_after_done", {63'd0, busy}, 64'd0);
    count_dones(W + 5, nd);
    check("ignore_no_extra_done", 64'(nd), 64'd0);
    run_op(32'd6, 32'd9, 1'b0, lat, bn);
    expect_res("after_ignore", 32'd15, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 32'd3; b = 32'd4; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    expect_res("rst", '0, 1'b0, 1'b0, 1'b0);
    count_dones(W + 5, nd);
    check("rst_no_done", 64'(nd), 64'd0);
    run_op(32'd3, 32'd4, 1'b0, lat, bn);
    check("rst_fresh_latency", 64'(lat), 64'(W + 1));
    expect_res("rst_fresh", 32'd7, 1'b0, 1'b0, 1'b0);

    // Randomized operations, mixing in corner operand values.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: rb = ra;
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), lat, bn);
      check("rand_latency", 64'(lat), 64'(W + 1));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
